// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage multiply/divide sequencer (divider launch, stall, HI/LO hold).
// Define MDU_MUL_PIPE_EN for a registered two-cycle multiply.
module mdu_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        opvalidE,
  input  logic        is_divE,
  input  logic        mdIsSignE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  input  logic        stall_extE,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        stall_mdE,
  output logic        md_validE,
  output logic [31:0] md_hiE,
  output logic [31:0] md_loE,
  output logic        md_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DIV_TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       stateNxt;
  logic [CNT_W-1:0] cnt;
  logic             live;
  logic [31:0]      hiQ;
  logic [31:0]      loQ;
  logic             errQ;
  logic [31:0]      opaQ;
  logic [31:0]      opbQ;
  logic             sgnQ;

  logic isIdle;
  logic isBusy;
  logic isDone;
  logic divReq;
  logic divZero;
  logic divLaunch;
  logic mulReq;
  logic mulStall;
  logic mulComb;
  logic doneOk;
  logic timeout;
  logic showRes;

  // live drops with rst so every output is quiet while reset is held
  assign isIdle = live & (state == IDLE);
  assign isBusy = live & (state == BUSY);
  assign isDone = live & (state == DONE);

  assign divReq    = isIdle & opvalidE & is_divE & ~flushE;
  assign divZero   = divReq & (srcbE == 32'd0);
  assign divLaunch = divReq & (srcbE != 32'd0);
  assign mulReq    = isIdle & opvalidE & ~is_divE & ~flushE;

`ifdef MDU_MUL_PIPE_EN
  assign mulStall = mulReq;
  assign mulComb  = 1'b0;
`else
  assign mulStall = 1'b0;
  assign mulComb  = mulReq;
`endif

  assign doneOk  = isBusy & div_ready & ~flushE;
  assign timeout = isBusy & ~flushE & ~div_ready
                 & (cnt == CNT_LAST);
  assign showRes = isDone & ~flushE;

  assign div_start  = divLaunch;
  assign div_cancel = (isBusy & flushE) | timeout;
  assign div_signed = sgnQ;
  assign div_opa    = opaQ;
  assign div_opb    = opbQ;

  assign stall_mdE = divReq | mulStall | isBusy;
  assign md_validE = showRes | mulComb;
  assign md_hiE    = showRes ? hiQ
                   : mulComb ? mul_hi : 32'd0;
  assign md_loE    = showRes ? loQ
                   : mulComb ? mul_lo : 32'd0;
  assign md_err    = errQ;

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: begin
        if (divLaunch)
          stateNxt = BUSY;
        else if (divZero | mulStall)
          stateNxt = DONE;
      end
      BUSY: begin
        if (flushE)
          stateNxt = IDLE;
        else if (div_ready | timeout)
          stateNxt = DONE;
      end
      DONE: begin
        if (flushE | ~stall_extE)
          stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      hiQ   <= 32'd0;
      loQ   <= 32'd0;
      errQ  <= 1'b0;
      opaQ  <= 32'd0;
      opbQ  <= 32'd0;
      sgnQ  <= 1'b0;
    end else begin
      live  <= 1'b1;
      state <= stateNxt;
      if (divLaunch) begin
        opaQ <= srcaE;
        opbQ <= srcbE;
        sgnQ <= mdIsSignE;
      end
      if (divLaunch)
        cnt <= '0;
      else if (isBusy)
        cnt <= cnt + 1'b1;
      if (divZero) begin
        hiQ <= srcaE;
        loQ <= 32'hFFFF_FFFF;
      end else if (doneOk) begin
        hiQ <= div_result[63:32];
        loQ <= div_result[31:0];
      end else if (timeout) begin
        hiQ <= 32'd0;
        loQ <= 32'd0;
      end else if (mulStall) begin
        hiQ <= mul_hi;
        loQ <= mul_lo;
      end
      if (timeout)
        errQ <= 1'b1;
    end
  end

endmodule
